// File: rtl/ste_microwire.sv
// -----------------------------------------------------------------------------
// ste_microwire
//   STE Microwire interface controller with LMC1992 command decoder.
//   The CPU writes the Microwire data and mask registers through the DMA-sound
//   register window. A data write starts a 16-slot serial transfer. During the
//   transfer both registers rotate left once per slot. Data bits under a set
//   mask bit are collected into an 11-bit receive register. At the end of the
//   transfer a valid LMC1992 command updates the tone and volume settings.
//
// Ports:
//   clk        system clock (32 MHz)
//   reset_n    asynchronous active-low reset
//   clk_8_en   8 MHz clock enable, one clk wide
//   din        CPU write data
//   addr       CPU word address [5:1] within the DMA-sound window
//   sel        DMA-sound window select
//   uds, lds   active-low byte strobes (upper / lower)
//   rw         1 = read, 0 = write
//   dout       read data, 0 when the block is not addressed
//   busy       a serial transfer is in progress
//   master_vol 0..40 (40 = 0 dB)
//   left_vol   0..20 (20 = 0 dB)
//   right_vol  0..20 (20 = 0 dB)
//   bass       0..12 (6 = flat)
//   treble     0..12 (6 = flat)
//   mix        LMC1992 mix code
// -----------------------------------------------------------------------------
module ste_microwire #(
  parameter int BIT_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_8_en,
  input  logic [15:0] din,
  input  logic [4:0]  addr,
  input  logic        sel,
  input  logic        uds,
  input  logic        lds,
  input  logic        rw,
  output logic [15:0] dout,
  output logic        busy,
  output logic [5:0]  master_vol,
  output logic [4:0]  left_vol,
  output logic [4:0]  right_vol,
  output logic [3:0]  bass,
  output logic [3:0]  treble,
  output logic [1:0]  mix
);

  localparam logic [4:0] ADDR_DATA = 5'h11;
  localparam logic [4:0] ADDR_MASK = 5'h12;
  localparam int         TW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   data_reg, mask_reg;
  logic [TW-1:0] tick;
  logic [3:0]    slot;
  logic [10:0]   rx, rx_nxt;
  logic [3:0]    rx_cnt, rx_cnt_nxt;

  logic          wr_cond, wr_prev, wr_pulse;
  logic          data_wr, mask_wr, start;
  logic          slot_end, last_slot;

  logic          cmd_ok;
  logic [2:0]    func;
  logic [5:0]    value;

  // ---------------------------------------------------------------------------
  // CPU bus decode. A write acts only on the first cycle of its strobe.
  // ---------------------------------------------------------------------------
  assign wr_cond  = sel & ~rw & (~uds | ~lds);
  assign wr_pulse = wr_cond & ~wr_prev;
  assign data_wr  = wr_pulse & (addr == ADDR_DATA);
  assign mask_wr  = wr_pulse & (addr == ADDR_MASK);
  assign start    = data_wr & (state == IDLE);

  assign busy      = (state == SHIFT);
  assign slot_end  = busy & clk_8_en & (tick == TICK_LAST);
  assign last_slot = slot_end & (slot == 4'd15);

  // Byte-lane merge of CPU write data into an existing register value.
  function automatic logic [15:0] merge_bytes(input logic [15:0] old_val,
                                              input logic [15:0] new_val,
                                              input logic        u_n,
                                              input logic        l_n);
    merge_bytes = {u_n ? old_val[15:8] : new_val[15:8],
                   l_n ? old_val[7:0]  : new_val[7:0]};
  endfunction

  always_comb begin
    dout = 16'h0000;
    if (sel & rw) begin
      if (addr == ADDR_DATA)      dout = data_reg;
      else if (addr == ADDR_MASK) dout = mask_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:  if (start)     state_nxt = SHIFT;
      SHIFT: if (last_slot) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers, counters and serial receive
  // ---------------------------------------------------------------------------
  // Receive value including the bit captured at this slot end, so the final
  // slot's bit is visible to the decoder on the same edge.
  always_comb begin
    rx_nxt     = rx;
    rx_cnt_nxt = rx_cnt;
    if (slot_end && mask_reg[15]) begin
      rx_nxt     = {rx[9:0], data_reg[15]};
      rx_cnt_nxt = (rx_cnt == 4'd11) ? 4'd11 : rx_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_prev  <= 1'b0;
      data_reg <= 16'h0000;
      mask_reg <= 16'h0000;
      tick     <= '0;
      slot     <= 4'd0;
      rx       <= 11'd0;
      rx_cnt   <= 4'd0;
    end else begin
      wr_prev <= wr_cond;
      if (start) begin
        data_reg <= merge_bytes(data_reg, din, uds, lds);
        tick     <= '0;
        slot     <= 4'd0;
        rx       <= 11'd0;
        rx_cnt   <= 4'd0;
      end else if (mask_wr && !busy) begin
        mask_reg <= merge_bytes(mask_reg, din, uds, lds);
      end else if (busy && clk_8_en) begin
        if (tick == TICK_LAST) begin
          tick     <= '0;
          slot     <= slot + 4'd1;
          rx       <= rx_nxt;
          rx_cnt   <= rx_cnt_nxt;
          // 16 rotations restore both registers to their written values.
          data_reg <= {data_reg[14:0], data_reg[15]};
          mask_reg <= {mask_reg[14:0], mask_reg[15]};
        end else begin
          tick <= tick + TW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // LMC1992 command decode: 2-bit address 10, 3-bit function, 6-bit value.
  // ---------------------------------------------------------------------------
  assign cmd_ok = (rx_cnt_nxt == 4'd11) && (rx_nxt[10:9] == 2'b10);
  assign func   = rx_nxt[8:6];
  assign value  = rx_nxt[5:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      master_vol <= 6'd40;
      left_vol   <= 5'd20;
      right_vol  <= 5'd20;
      bass       <= 4'd6;
      treble     <= 4'd6;
      mix        <= 2'b01;
    end else if (last_slot && cmd_ok) begin
      case (func)
        3'b000: if (value[1:0] != 2'b11) mix <= value[1:0];
        3'b001: bass       <= (value[3:0] > 4'd12) ? 4'd12 : value[3:0];
        3'b010: treble     <= (value[3:0] > 4'd12) ? 4'd12 : value[3:0];
        3'b011: master_vol <= (value > 6'd40) ? 6'd40 : value;
        3'b100: right_vol  <= (value[4:0] > 5'd20) ? 5'd20 : value[4:0];
        3'b101: left_vol   <= (value[4:0] > 5'd20) ? 5'd20 : value[4:0];
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ste_microwire.md
# ste_microwire

STE Microwire interface controller and LMC1992 command decoder for the audio subsystem. It exposes the Microwire data and mask registers to the CPU inside the STE DMA-sound register window and serialises each written frame over 16 µs, rotating both registers as the hardware does. It decodes the received LMC1992 command and holds the resulting master, left and right volume, bass, treble and mix settings. The audio mixer consumes these settings in place of fixed gains.

## Interface
Parameters:
- `BIT_TICKS`, default 8: `clk_8_en` ticks per Microwire bit slot (8 gives 1 µs).

Ports:
- `clk`  in  1  system clock, 32 MHz
- `reset_n`  in  1  asynchronous, active-low reset
- `clk_8_en`  in  1  8 MHz clock enable, one `clk` wide
- `din`  in  16  CPU write data
- `addr`  in  5  CPU word address [5:1] within the DMA-sound window
- `sel`  in  1  DMA-sound window select
- `uds`, `lds`  in  1 each  byte strobes, active-low
- `rw`  in  1  1 = read, 0 = write
- `dout`  out  16  read data; 0 when the block is not addressed
- `busy`  out  1  a transfer is in progress
- `master_vol`  out  6  0..40, where 40 = 0 dB
- `left_vol`, `right_vol`  out  5 each  0..20, where 20 = 0 dB
- `bass`, `treble`  out  4 each  0..12, where 6 = flat
- `mix`  out  2  LMC1992 mix code

## Operation
- Registers:
  - Data register is at addr 5'h11.
  - Mask register is at addr 5'h12.
  - `dout` returns the current register value while `sel & rw` and addr matches; otherwise `dout` is 0.
- Writes:
  - The write condition is `sel & ~rw & (~uds | ~lds)`.
  - A write acts once, in the first cycle the condition is true after it was false.
  - The upper byte is written if `~uds`; the lower byte is written if `~lds`.
- Transfer start:
  - A write to the data register while idle starts a transfer.
  - A write to the mask register never starts one.
  - While `busy`, writes to both registers are ignored.
- States:
  - IDLE → SHIFT on a data write.
  - SHIFT → IDLE after 16 bit slots.
- SHIFT:
  - The slot counter (0..15) and the tick counter (0..`BIT_TICKS`-1) advance on `clk_8_en`.
  - At the end of each slot, if `mask[15]=1`, `data[15]` shifts into an 11-bit receive register and the received-bit count increments, saturating at 11.
  - Both registers then rotate left by 1.
  - After 16 rotations both registers hold their written values again.
- End of transfer:
  - The command applies only if the received count equals 11 and receive[10:9] = 2'b10.
  - The function code is receive[8:6] and the value is receive[5:0].
- Function codes:
  - 000: `mix` = value[1:0]. Code 11 is ignored.
  - 001: `bass` = value[3:0].
  - 010: `treble` = value[3:0].
  - 011: `master_vol` = value.
  - 100: `right_vol` = value[4:0].
  - 101: `left_vol` = value[4:0].
  - 110 and 111 are ignored.
- Clamping: `master_vol` saturates at 40, left/right at 20, bass/treble at 12.
- If fewer than 11 bits arrive, the whole frame is discarded. If more than 11 arrive, only the last 11 are kept; the count stays at 11 and the receive register keeps shifting.

## Timing
- Reset values, applied asynchronously:
  - `busy` = 0, data and mask = 0, `dout` = 0.
  - `master_vol` = 40, `left_vol` = `right_vol` = 20, `bass` = `treble` = 6, `mix` = 2'b01.
- Start of transfer:
  - `busy` rises on the `clk` edge that captures the data write.
  - The tick counter is reset to 0 on that edge.
- Rotations:
  - The first rotation occurs on the `BIT_TICKS`-th `clk_8_en` tick after start.
  - One rotation follows every `BIT_TICKS` ticks, 16 in total: 128 ticks, or 16 µs at defaults.
- End of transfer:
  - On the 16th rotation edge, `busy` falls and the decoded outputs update together.
  - A new data write is accepted from the next cycle.
- `dout` is combinational from the registers, so a read mid-transfer shows the rotated value.
- If `reset_n` is asserted mid-transfer, the transfer aborts and every output returns to its reset value immediately. No partial command is applied.
- If a data write and the 16th rotation fall in the same cycle, the write is ignored because `busy` is still 1 in that cycle.

## Test plan
- Reset: assert `reset_n`=0 mid-SHIFT → `busy`=0, `master_vol`=40, `left_vol`=20, `bass`=6, `mix`=01, `dout`=0.
- Master volume:
  - Write mask 0x07FF, then data 0x04D4.
  - `busy` stays high for exactly 128 `clk_8_en` ticks, then `master_vol`=20.
  - Reads after transfer: data register 0x04D4, mask register 0x07FF.
- Rotation readback: during the 0x04D4/0x07FF transfer, after one rotation, data reads 0x09A8 and mask reads 0x0FFE.
- Sparse mask and clamp:
  - Mask 0xFFE0, data 0x9D00 → `master_vol`=40.
  - Mask 0x07FF, data 0x04FF → `master_vol`=40 (clamped from 63).
  - Mask 0x07FF, data 0x054F → `left_vol`=15.
- Rejection:
  - Mask 0x07FF, data 0x00E8 (address 00) → all settings unchanged.
  - Mask 0x03FF, data 0x04D4 (10 bits received) → all settings unchanged.
- Busy lockout: during a transfer, write data 0x0000 and mask 0x0000 → ignored; the transfer completes with the original command, and readback afterwards returns the original values.
